// File: rtl/ntt_stage_controller.sv
// ---------------------------------------------------------------------------
// ntt_stage_controller
//
// Sequences a complete 256-point Kyber NTT (or unscaled inverse NTT) over a
// dual-port coefficient RAM. The transform has 7 layers. Each layer reads 128
// coefficient pairs in place, sends each pair with its twiddle index to an
// external butterfly, and writes the returned U/V back to the addresses the
// pair was read from.
//
// Ports:
//   clk, r               clock; synchronous active-high reset
//   i_start, i_inverse   run request and mode (both sampled only in IDLE)
//   o_busy, o_done       run in progress / one-cycle completion pulse
//   o_protocol_err       sticky: butterfly returned a result nobody awaited
//   o_rd_en, o_rd_addr_* pair read strobe and addresses (j, j+len)
//   i_rd_data_*          RAM read data, valid one cycle after o_rd_en
//   o_bf_valid_in, o_bf_inverse, o_bf_in_*, o_zeta_idx   pair to butterfly
//   i_bf_valid_out, i_bf_u, i_bf_v                      butterfly result
//   o_wr_en, o_wr_addr_*, o_wr_data_*                   in-place writeback
// ---------------------------------------------------------------------------
module ntt_stage_controller #(
    parameter int N          = 256,
    parameter int BF_LATENCY = 3,
    parameter int W          = 12
) (
    input  logic         clk,
    input  logic         r,
    input  logic         i_start,
    input  logic         i_inverse,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_protocol_err,
    output logic         o_rd_en,
    output logic [7:0]   o_rd_addr_a,
    output logic [7:0]   o_rd_addr_b,
    input  logic [W-1:0] i_rd_data_a,
    input  logic [W-1:0] i_rd_data_b,
    output logic         o_bf_valid_in,
    output logic         o_bf_inverse,
    output logic [W-1:0] o_bf_in_1,
    output logic [W-1:0] o_bf_in_2,
    output logic [6:0]   o_zeta_idx,
    input  logic         i_bf_valid_out,
    input  logic [W-1:0] i_bf_u,
    input  logic [W-1:0] i_bf_v,
    output logic         o_wr_en,
    output logic [7:0]   o_wr_addr_a,
    output logic [7:0]   o_wr_addr_b,
    output logic [W-1:0] o_wr_data_a,
    output logic [W-1:0] o_wr_data_b
);

    localparam int HALF   = N / 2;           // pairs per layer
    localparam int LAYERS = $clog2(N) - 1;   // 7 layers for N=256

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic         r_inverse;
    logic [2:0]   r_layer;
    logic [6:0]   r_pair;
    logic         r_bf_valid;
    logic [6:0]   r_zeta;
    logic [7:0]   r_outstanding;
    logic         r_protocol_err;
    logic [7:0]   r_pipe_a [BF_LATENCY+1];
    logic [7:0]   r_pipe_b [BF_LATENCY+1];

    logic         w_issue;
    logic [3:0]   w_shift;
    logic [7:0]   w_len;
    logic [7:0]   w_group;
    logic [7:0]   w_addr_a;
    logic [7:0]   w_addr_b;
    logic [6:0]   w_zeta;
    logic         w_wr_en;
    logic [7:0]   w_out_next;

    assign w_issue = (r_state == S_IDLE) ? 1'b0 : (r_state == S_ISSUE);

    // Pair index p (0..127) maps to j = group*2*len + (p mod len), which
    // simplifies to p + group*len with group = p / len and len = 2^shift.
    // Forward layers run len = 128..2, inverse layers run len = 2..128.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise a latch is inferred.
        w_shift  = r_inverse ? ({1'b0, r_layer} + 4'd1) : (4'd7 - {1'b0, r_layer});
        w_len    = 8'd1 << w_shift;
        w_group  = {1'b0, r_pair} >> w_shift;
        w_addr_a = {1'b0, r_pair} + (w_group << w_shift);
        w_addr_b = w_addr_a + w_len;
        // Forward twiddles count up from 2^layer; inverse twiddles count down
        // from 127 across the whole run, i.e. from (128 >> layer) - 1.
        w_zeta   = r_inverse ? ((7'd127 >> r_layer) - w_group[6:0])
                             : ((7'd1 << r_layer) + w_group[6:0]);
    end

    // A result with nothing outstanding is a protocol fault and is not written.
    assign w_wr_en    = i_bf_valid_out && (r_outstanding != 8'd0);
    assign w_out_next = r_outstanding + {7'd0, r_bf_valid} - {7'd0, w_wr_en};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (r) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_ISSUE;
            S_ISSUE: if (r_pair == 7'(HALF - 1)) w_next_state = S_DRAIN;
            // The layer is finished when the last outstanding result is
            // written; the next layer's reads then see every write.
            S_DRAIN: if (w_wr_en && (w_out_next == 8'd0)) begin
                         w_next_state = (r_layer == 3'(LAYERS - 1)) ? S_DONE : S_ISSUE;
                     end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        o_done      = (r_state == S_DONE);
        o_rd_en     = w_issue;
        o_rd_addr_a = w_issue ? w_addr_a : 8'd0;
        o_rd_addr_b = w_issue ? w_addr_b : 8'd0;
        o_wr_en     = w_wr_en;
        o_wr_addr_a = w_wr_en ? r_pipe_a[BF_LATENCY] : 8'd0;
        o_wr_addr_b = w_wr_en ? r_pipe_b[BF_LATENCY] : 8'd0;
        o_wr_data_a = w_wr_en ? i_bf_u : '0;
        o_wr_data_b = w_wr_en ? i_bf_v : '0;
    end

    // RAM data arrives one cycle after the read, aligned with r_bf_valid.
    assign o_bf_valid_in  = r_bf_valid;
    assign o_bf_inverse   = r_inverse;
    assign o_bf_in_1      = r_bf_valid ? i_rd_data_a : '0;
    assign o_bf_in_2      = r_bf_valid ? i_rd_data_b : '0;
    assign o_zeta_idx     = r_zeta;
    assign o_protocol_err = r_protocol_err;

    // ---------------- control counters and butterfly issue ----------------
    always_ff @(posedge clk) begin
        if (r) begin
            r_inverse      <= 1'b0;
            r_layer        <= 3'd0;
            r_pair         <= 7'd0;
            r_bf_valid     <= 1'b0;
            r_zeta         <= 7'd0;
            r_outstanding  <= 8'd0;
            r_protocol_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_inverse <= i_inverse;
                r_layer   <= 3'd0;
                r_pair    <= 7'd0;
            end
            // The 7-bit pair counter wraps to 0 after the 128th pair.
            if (w_issue) begin
                r_pair <= r_pair + 7'd1;
            end
            if ((r_state == S_DRAIN) && (w_next_state == S_ISSUE)) begin
                r_layer <= r_layer + 3'd1;
            end
            r_bf_valid    <= w_issue;
            r_zeta        <= w_issue ? w_zeta : 7'd0;
            r_outstanding <= w_out_next;
            if (i_bf_valid_out && (r_outstanding == 8'd0)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // ---------------- read-address pipe ----------------
    // Stage 0 lines up with o_bf_valid_in; stage BF_LATENCY lines up with the
    // matching i_bf_valid_out, giving the in-place writeback addresses.
    always_ff @(posedge clk) begin
        // NOTE: this array is a short shift register, not a RAM, so it is
        // reset so that a mid-run reset drops every in-flight address.
        if (r) begin
            for (int i = 0; i <= BF_LATENCY; i++) begin
                r_pipe_a[i] <= 8'd0;
                r_pipe_b[i] <= 8'd0;
            end
        end else begin
            r_pipe_a[0] <= w_issue ? w_addr_a : 8'd0;
            r_pipe_b[0] <= w_issue ? w_addr_b : 8'd0;
            for (int i = 1; i <= BF_LATENCY; i++) begin
                r_pipe_a[i] <= r_pipe_a[i-1];
                r_pipe_b[i] <= r_pipe_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_ntt_stage_controller
//
// Drives ntt_stage_controller against a behavioural coefficient RAM and a
// latency-3 Kyber butterfly, and compares schedules, timing and final RAM
// contents with hand-computed vectors and a software NTT / inverse NTT.
// ---------------------------------------------------------------------------
module tb_ntt_stage_controller;

    localparam int Q      = 3329;
    localparam int NPAIRS = 896;

    logic        clk = 1'b0;
    logic        r;
    logic        start;
    logic        inv_in;
    logic        busy, done, protocol_err;
    logic        rd_en;
    logic [7:0]  rd_addr_a, rd_addr_b;
    logic [11:0] rd_data_a = '0;
    logic [11:0] rd_data_b = '0;
    logic        bf_valid_in, bf_inverse;
    logic [11:0] bf_in_1, bf_in_2;
    logic [6:0]  zeta_idx;
    logic        bf_valid_out;
    logic [11:0] bf_u, bf_v;
    logic        wr_en;
    logic [7:0]  wr_addr_a, wr_addr_b;
    logic [11:0] wr_data_a, wr_data_b;

    logic        inject;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [11:0] ld_data;

    always #5 clk = ~clk;

    ntt_stage_controller #(.N(256), .BF_LATENCY(3), .W(12)) dut (
        .clk            (clk),
        .r              (r),
        .i_start        (start),
        .i_inverse      (inv_in),
        .o_busy         (busy),
        .o_done         (done),
        .o_protocol_err (protocol_err),
        .o_rd_en        (rd_en),
        .o_rd_addr_a    (rd_addr_a),
        .o_rd_addr_b    (rd_addr_b),
        .i_rd_data_a    (rd_data_a),
        .i_rd_data_b    (rd_data_b),
        .o_bf_valid_in  (bf_valid_in),
        .o_bf_inverse   (bf_inverse),
        .o_bf_in_1      (bf_in_1),
        .o_bf_in_2      (bf_in_2),
        .o_zeta_idx     (zeta_idx),
        .i_bf_valid_out (bf_valid_out),
        .i_bf_u         (bf_u),
        .i_bf_v         (bf_v),
        .o_wr_en        (wr_en),
        .o_wr_addr_a    (wr_addr_a),
        .o_wr_addr_b    (wr_addr_b),
        .o_wr_data_a    (wr_data_a),
        .o_wr_data_b    (wr_data_b)
    );

    // ---------------- models ----------------
    int zetas [128];
    int ref_poly [256];
    logic [11:0] mem [256];

    function automatic int modq(input int x);
        int m;
        m = x % Q;
        if (m < 0) m += Q;
        return m;
    endfunction

    function automatic logic [23:0] bf_calc(input logic [11:0] a, input logic [11:0] b,
                                            input logic [6:0] z, input logic inv);
        int ia, ib, t, u, v;
        ia = int'(a);
        ib = int'(b);
        if (!inv) begin
            t = modq(zetas[z] * ib);
            u = modq(ia + t);
            v = modq(ia - t);
        end else begin
            u = modq(ia + ib);
            v = modq(zetas[z] * (ib - ia));
        end
        return {u[11:0], v[11:0]};
    endfunction

    // Coefficient RAM: registered read, in-place write, tb load port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
    end

    // Butterfly with 3 cycles from valid_in to valid_out; it keeps running
    // through a controller reset, so in-flight results still come back.
    logic        bfm_v [3] = '{default: 1'b0};
    logic [23:0] bfm_d [3] = '{default: 24'd0};
    always @(posedge clk) begin
        bfm_v[0] <= bf_valid_in;
        bfm_d[0] <= bf_calc(bf_in_1, bf_in_2, zeta_idx, bf_inverse);
        for (int i = 1; i < 3; i++) begin
            bfm_v[i] <= bfm_v[i-1];
            bfm_d[i] <= bfm_d[i-1];
        end
    end
    assign bf_valid_out = bfm_v[2] | inject;
    assign bf_u         = bfm_d[2][23:12];
    assign bf_v         = bfm_d[2][11:0];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int idx;
        int a;
        int b;
        int z;
    } pair_vec_t;

    int log_a [NPAIRS];
    int log_b [NPAIRS];
    int log_z [NPAIRS];
    int rd_n, bv_n, wr_n, inv_bad, busy_at_done;

    task automatic load_poly(input bit zero);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ref_poly[i] = zero ? 0 : int'($urandom_range(Q - 1, 0));
            ld_data = 12'(ref_poly[i]);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic ref_transform(input bit inv);
        int k, t, zeta;
        if (!inv) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    zeta = zetas[k];
                    k++;
                    for (int j = st; j < st + len; j++) begin
                        t = modq(zeta * ref_poly[j + len]);
                        ref_poly[j + len] = modq(ref_poly[j] - t);
                        ref_poly[j]       = modq(ref_poly[j] + t);
                    end
                end
            end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    zeta = zetas[k];
                    k--;
                    for (int j = st; j < st + len; j++) begin
                        t = ref_poly[j];
                        ref_poly[j]       = modq(t + ref_poly[j + len]);
                        ref_poly[j + len] = modq(zeta * (ref_poly[j + len] - t));
                    end
                end
            end
        end
    endtask

    function automatic int ram_mismatches();
        int m;
        m = 0;
        for (int i = 0; i < 256; i++) begin
            if (int'(mem[i]) != ref_poly[i]) m++;
        end
        return m;
    endfunction

    // Start at cycle 0; optionally re-pulse start (with the opposite mode)
    // at cycle restart_at. Logs the schedule until done or the cycle budget.
    task automatic run_transform(input logic inv, input int restart_at, output int done_at);
        done_at = -1;
        rd_n = 0; bv_n = 0; wr_n = 0; inv_bad = 0; busy_at_done = -1;
        @(negedge clk);
        start  = 1'b1;
        inv_in = inv;
        for (int t = 1; t <= 1200 && done_at < 0; t++) begin
            @(negedge clk);
            if (rd_en) begin
                if (rd_n < NPAIRS) begin
                    log_a[rd_n] = int'(rd_addr_a);
                    log_b[rd_n] = int'(rd_addr_b);
                end
                rd_n++;
            end
            if (bf_valid_in) begin
                if (bv_n < NPAIRS) log_z[bv_n] = int'(zeta_idx);
                if (bf_inverse != inv) inv_bad++;
                bv_n++;
            end
            if (wr_en) wr_n++;
            if (done) begin
                done_at      = t;
                busy_at_done = int'(busy);
            end
            start  = (t == restart_at);
            inv_in = (t == restart_at) ? ~inv : inv;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int done_at);
        check({tag, "_done_cycle"}, done_at, 925);
        check({tag, "_busy_in_done"}, busy_at_done, 0);
        check({tag, "_rd_count"}, rd_n, NPAIRS);
        check({tag, "_bf_valid_in_count"}, bv_n, NPAIRS);
        check({tag, "_wr_count"}, wr_n, NPAIRS);
        check({tag, "_bf_inverse_wrong"}, inv_bad, 0);
        check({tag, "_protocol_err"}, int'(protocol_err), 0);
        check({tag, "_ram_mismatches"}, ram_mismatches(), 0);
    endtask

    task automatic check_table(input string tag, input pair_vec_t vecs [8]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_rd_a[%0d]", tag, vecs[i].idx), log_a[vecs[i].idx], vecs[i].a);
            check($sformatf("%s_rd_b[%0d]", tag, vecs[i].idx), log_b[vecs[i].idx], vecs[i].b);
            check($sformatf("%s_zeta[%0d]", tag, vecs[i].idx), log_z[vecs[i].idx], vecs[i].z);
        end
    endtask

    initial begin
        pair_vec_t fwd_vecs [8];
        pair_vec_t inv_vecs [8];
        int done_at, strobes, busy_seen, nonzero, br, z;

        // Hand-computed schedule points: {pair index in run, addr a, addr b, zeta}.
        fwd_vecs = '{'{0, 0, 128, 1},   '{1, 1, 129, 1},   '{127, 127, 255, 1},
                     '{128, 0, 64, 2},  '{192, 128, 192, 3}, '{288, 64, 96, 5},
                     '{768, 0, 2, 64},  '{895, 253, 255, 127}};
        inv_vecs = '{'{0, 0, 2, 127},   '{1, 1, 3, 127},   '{2, 4, 6, 126},
                     '{127, 253, 255, 64}, '{128, 0, 4, 63}, '{132, 8, 12, 62},
                     '{768, 0, 128, 1}, '{895, 127, 255, 1}};

        // zetas[k] = 17^bitrev7(k) mod q
        for (int k = 0; k < 128; k++) begin
            br = 0;
            for (int b = 0; b < 7; b++) br |= ((k >> b) & 1) << (6 - b);
            z = 1;
            for (int e = 0; e < br; e++) z = (z * 17) % Q;
            zetas[k] = z;
        end

        r = 1'b1; start = 1'b0; inv_in = 1'b0; inject = 1'b0;
        ld_en = 1'b0; ld_addr = 8'd0; ld_data = 12'd0;
        repeat (2) @(negedge clk);
        r = 1'b0;

        // ---- reset state ----
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_protocol_err", int'(protocol_err), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_bf_valid_in", int'(bf_valid_in), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_zeta_idx", int'(zeta_idx), 0);
        check("rst_bf_inverse", int'(bf_inverse), 0);
        strobes = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rd_en || bf_valid_in || wr_en || busy || done) strobes++;
        end
        check("idle_strobes", strobes, 0);

        // ---- forward NTT, with an ignored start (mode flipped) at cycle 10 ----
        load_poly(1'b0);
        ref_transform(1'b0);
        run_transform(1'b0, 10, done_at);
        check_run("fwd", done_at);
        check_table("fwd", fwd_vecs);
        @(negedge clk);
        check("fwd_done_pulse_width", int'(done), 0);
        check("fwd_busy_after", int'(busy), 0);

        // ---- inverse NTT ----
        load_poly(1'b0);
        ref_transform(1'b1);
        run_transform(1'b1, -1, done_at);
        check_run("inv", done_at);
        check_table("inv", inv_vecs);

        // ---- all-zero input stays zero ----
        load_poly(1'b1);
        run_transform(1'b0, -1, done_at);
        check("zero_done_cycle", done_at, 925);
        nonzero = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 12'd0) nonzero++;
        check("zero_nonzero_coeffs", nonzero, 0);

        // ---- reset at cycle 50 of a run ----
        load_poly(1'b0);
        @(negedge clk);
        start  = 1'b1;
        inv_in = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 50) r = 1'b1;
        end
        strobes = 0;
        busy_seen = 0;
        for (int t = 51; t <= 70; t++) begin
            @(negedge clk);
            r = 1'b0;
            if (rd_en || bf_valid_in || wr_en) strobes++;
            if (busy) busy_seen++;
        end
        check("midrst_strobes", strobes, 0);
        check("midrst_busy", busy_seen, 0);
        check("midrst_late_result_flagged", int'(protocol_err), 1);
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        check("midrst_err_cleared_by_r", int'(protocol_err), 0);

        // ---- fresh run after the reset ----
        load_poly(1'b0);
        ref_transform(1'b0);
        run_transform(1'b0, -1, done_at);
        check_run("fresh", done_at);

        // ---- stray butterfly result while idle ----
        @(negedge clk);
        inject = 1'b1;
        #1;
        check("stray_wr_en", int'(wr_en), 0);
        @(negedge clk);
        inject = 1'b0;
        check("stray_protocol_err", int'(protocol_err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_stage_controller.md
Name: ntt_stage_controller

Overview:
- Initiator side of the butterfly interface: sequences a full 256-point Kyber NTT or inverse NTT (7 layers, q=3329) over a dual-port coefficient RAM.
- Per layer: reads coefficient pairs, issues them with a twiddle index to Butterfly_unit (valid_in/inverse), collects U/V on valid_out, writes them back in place.
- Sits between the coefficient RAM and the butterfly datapath. The final n^-1 scaling of the inverse transform is out of scope.

Parameters:
- N, 256, polynomial length (fixed for Kyber; only 256 is supported).
- BF_LATENCY, 3, cycles from bf_valid_in to the matching bf_valid_out.
- W, 12, coefficient width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- r  in  1  reset, synchronous, active-high.
- start  in  1  1-cycle request to run a transform; sampled only in IDLE.
- inverse  in  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  1-cycle pulse at completion.
- protocol_err  out  1  sticky; set on bf_valid_out with no transfer outstanding; cleared only by r.
- rd_en  out  1  RAM read strobe.
- rd_addr_a, rd_addr_b  out  8 each  pair addresses j and j+len.
- rd_data_a, rd_data_b  in  W each  RAM data, valid 1 cycle after rd_en.
- bf_valid_in  out  1  pair valid to butterfly.
- bf_inverse  out  1  mode to butterfly.
- bf_in_1, bf_in_2  out  W each  coefficients to butterfly.
- zeta_idx  out  7  twiddle index for the pair on bf_in_*.
- bf_valid_out  in  1  butterfly result valid.
- bf_u, bf_v  in  W each  butterfly results.
- wr_en  out  1  RAM write strobe.
- wr_addr_a, wr_addr_b  out  8 each  writeback addresses.
- wr_data_a, wr_data_b  out  W each  writeback data.

Behaviour:
- Reset: all outputs 0, state IDLE, address/valid pipe cleared, protocol_err 0.
- States and transitions:
  - IDLE -> ISSUE on start; latch inverse.
  - ISSUE -> DRAIN after the 128th pair of the layer.
  - DRAIN -> ISSUE (next layer) once the last write of the layer has occurred.
  - DRAIN -> DONE after layer 7.
  - DONE -> IDLE after 1 cycle; done=1 in DONE and busy=0 in the same cycle.
- Forward schedule: len = 128, 64, ..., 2. Groups at start = 0, 2len, ... For each group, k increments, starting at 1. Pairs are (j, j+len) for j = start..start+len-1; zeta_idx = k.
- Inverse schedule: len = 2, 4, ..., 128. k starts at 127 and decrements per group.
- Issue: 1 pair per ISSUE cycle, 128 per layer, with rd_en=1. In the next cycle: bf_valid_in=1, bf_in_1=rd_data_a, bf_in_2=rd_data_b, zeta_idx registered alongside, bf_inverse = latched mode.
- Address pipe: rd addresses are carried through a 1+BF_LATENCY-deep pipe.
- Writeback: on bf_valid_out, combinationally drive wr_en=1, wr_data_a=bf_u, wr_data_b=bf_v, and addresses from the pipe head.
- Timing with start sampled at cycle t0 and BF_LATENCY=3:
  - rd_en in t1..t128.
  - bf_valid_in in t2..t129.
  - wr_en in t5..t132.
  - Next layer reads begin at t133, so reads always observe the prior layer's writes (no RAW hazard).
  - Per layer = 128+1+BF_LATENCY cycles; done at t = 7*132+1 = 925.
- Outstanding counter: +1 on bf_valid_in, -1 on wr_en, both allowed in the same cycle.
  - bf_valid_out when the count is 0 sets protocol_err and suppresses wr_en.
- start while busy is ignored; inverse is not re-sampled mid-run.
- Reset mid-operation: next cycle IDLE, no further rd_en/bf_valid_in/wr_en, pipe valids dropped; later results returned by the butterfly are flagged via protocol_err.

Test Plan:
- Assert r for 2 cycles, then release -> all outputs 0, busy=0; no strobes for 20 idle cycles.
- Forward start -> first rd (0,128), zeta_idx=1 on the first bf_valid_in; 128th rd (127,255); layer 2 first (0,64) zeta 2, and (128,192) zeta 3.
- Forward full run with a latency-3 behavioural butterfly and RAM model -> 896 wr_en pulses, done at cycle 925 after start, RAM equals the software NTT. An all-zero input stays zero.
- Inverse start -> first pairs (0,2) zeta 127 and (4,6) zeta 126; last layer (0,128) zeta 1, with bf_inverse=1 throughout. RAM equals the software invNTT (unscaled).
- Assert r at cycle 50 of a run -> no rd_en/wr_en after reset, busy=0; a fresh start completes correctly. The model's late bf_valid_out sets protocol_err.
- start pulsed at cycle 10 of a run -> ignored and done still at 925. Inject bf_valid_out in IDLE -> protocol_err=1, wr_en stays 0.
